// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // Word aligned and the whole word inside IMEM; 33-bit compare so pc+3 cannot wrap.
  function automatic logic fetch_legal(input logic [XLEN-1:0] pc,
                                       input int unsigned     imem_size);
    logic [XLEN:0] last_byte;
    last_byte   = {1'b0, pc} + (XLEN+1)'(INSTR_BYTES - 1);
    fetch_legal = (pc[1:0] == 2'b00) && (last_byte < (XLEN+1)'(imem_size));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc,instr} entries with push, pop and flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch FIFO from IMEM,
// handles redirects and halts on illegal fetch addresses.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_SIZE  = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] instr_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  instr_count_q, instr_count_d;

  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;
  logic          pop;
  logic          push;
  logic          fetch_try;
  logic          legal;
  logic          has_room;

  always_comb begin
    pop       = !fifo_empty && if_ready;
    legal     = fetch_legal(fetch_pc_q, IMEM_SIZE);
    has_room  = (fifo_count < CW'(FIFO_DEPTH)) || pop;
    fetch_try = (state_q == RUN) && fetch_en && !redirect_valid;
    push      = fetch_try && legal && has_room;

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    instr_count_d = instr_count_q + 32'(pop);

    // Redirect overrides everything in both states; a pop in the same cycle still counts.
    if (redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
    end else if (fetch_try && !legal) begin
      state_d    = FAULT;
      fault_d    = 1'b1;
      fault_pc_d = fetch_pc_q;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      instr_count_q <= instr_count_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc_q, imem_instr}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_pc     = fetch_pc_q;
  assign if_valid    = !fifo_empty;
  assign if_pc       = fifo_empty ? '0 : fifo_head[63:32];
  assign if_instr    = fifo_empty ? '0 : fifo_head[31:0];
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table plus hand-written corner sequences.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0),
    .IMEM_SIZE  (1024),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .instr_count    (instr_count)
  );

  // IMEM image; addresses beyond the image return a tag derived from the address.
  function automatic logic [31:0] imem_model(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0000;
      32'h4:   return 32'h0040_0093;
      32'h8:   return 32'h0010_0113;
      32'hC:   return 32'h0020_81b3;
      default: return {16'hBEEF, a[15:0]};
    endcase
  endfunction

  always_comb imem_instr = imem_model(imem_pc);

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eimem;
    logic        ef;
    logic [31:0] efpc;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic fe, input logic rdy,
                              input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic [31:0] eimem,
                              input logic ef, input logic [31:0] efpc,
                              input logic [31:0] ecnt);
    vec_t v;
    v.rst = r;  v.fe = fe;   v.rdy = rdy;       v.rv = rv;     v.rpc = rpc;
    v.ev  = ev; v.epc = epc; v.einstr = einstr; v.eimem = eimem;
    v.ef  = ef; v.efpc = efpc; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Each row: compare outputs at the negedge, then drive inputs for the next edge.
    //           rst fe rdy rv rpc     ev epc    instr         imem    f fpc    cnt
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'h0,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h0, 32'h0,        32'h4,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h4, 32'h00400093, 32'h8,  0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h8, 32'h00100113, 32'hC,  0, 32'h0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0,        32'hC,  0, 32'h0, 3));
    // back-pressure: FIFO fills, fetch stalls at pc 8
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0,        32'h0,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0,        32'h4,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0,        32'h8,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0,        32'h8,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 1, 32'h0, 32'h0,        32'h8,  0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 1, 32'h0, 32'h0,        32'h8,  0, 32'h0, 0));
    // full with push+pop, then redirect to 0xC while FIFO holds 4,8
    vecs.push_back(mk(0, 1, 1, 1, 32'hC, 1, 32'h4, 32'h00400093, 32'hC,  0, 32'h0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'hC,  0, 32'h0, 2));
    // misaligned redirect target 0x6
    vecs.push_back(mk(0, 1, 1, 1, 32'h6, 1, 32'hC, 32'h002081b3, 32'h10, 0, 32'h0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'h6,  0, 32'h0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'h6,  1, 32'h6, 3));
    vecs.push_back(mk(0, 1, 1, 1, 32'h4, 0, 32'h0, 32'h0,        32'h6,  1, 32'h6, 3));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'h4,  0, 32'h6, 3));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 1, 32'h4, 32'h00400093, 32'h8,  0, 32'h6, 3));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0,        32'h8,  0, 32'h6, 4));

    foreach (vecs[i]) begin
      @(negedge clk);
      chk($sformatf("v%0d.if_valid", i),    32'(if_valid),  32'(vecs[i].ev));
      chk($sformatf("v%0d.if_pc", i),       if_pc,          vecs[i].epc);
      chk($sformatf("v%0d.if_instr", i),    if_instr,       vecs[i].einstr);
      chk($sformatf("v%0d.imem_pc", i),     imem_pc,        vecs[i].eimem);
      chk($sformatf("v%0d.fault", i),       32'(fault),     32'(vecs[i].ef));
      chk($sformatf("v%0d.fault_pc", i),    fault_pc,       vecs[i].efpc);
      chk($sformatf("v%0d.instr_count", i), instr_count,    vecs[i].ecnt);
      rst            = vecs[i].rst;
      fetch_en       = vecs[i].fe;
      if_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
    end

    // Upper IMEM boundary: 0x3FC is the last legal word, 0x400 faults.
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F8;
    @(negedge clk);
    chk("bnd.imem_pc0", imem_pc, 32'h3F8);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("bnd.if_pc0", if_pc, 32'h3F8);
    chk("bnd.if_instr0", if_instr, 32'hBEEF03F8);
    chk("bnd.imem_pc1", imem_pc, 32'h3FC);
    @(negedge clk);
    chk("bnd.if_pc1", if_pc, 32'h3FC);
    chk("bnd.if_instr1", if_instr, 32'hBEEF03FC);
    chk("bnd.imem_pc2", imem_pc, 32'h400);
    chk("bnd.fault0", 32'(fault), 32'd0);
    @(negedge clk);
    chk("bnd.fault1", 32'(fault), 32'd1);
    chk("bnd.fault_pc", fault_pc, 32'h400);
    chk("bnd.if_valid", 32'(if_valid), 32'd0);
    chk("bnd.count", instr_count, 32'd2);
    @(negedge clk);
    chk("bnd.fault_hold", 32'(fault), 32'd1);
    chk("bnd.pc_hold", imem_pc, 32'h400);

    // Asynchronous reset while the FIFO is full.
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (3) @(negedge clk);
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst.pre_valid", 32'(if_valid), 32'd1);
    chk("arst.pre_if_pc", if_pc, 32'h8);
    chk("arst.pre_count", instr_count, 32'd2);
    chk("arst.pre_imem_pc", imem_pc, 32'h10);
    #2 rst = 1'b1;
    #1;
    chk("arst.if_valid", 32'(if_valid), 32'd0);
    chk("arst.imem_pc", imem_pc, 32'h0);
    chk("arst.count", instr_count, 32'd0);
    chk("arst.fault", 32'(fault), 32'd0);
    chk("arst.if_pc", if_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
